// File: rtl/hsc_membus_pkg.sv
// Shared types and helpers for the hs32 multiplexed memory-bus controller.
package hsc_membus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ALE_LO,
        ALE_HI,
        TURN,
        BEAT0,
        BEAT1,
        DONE
    } state_t;

    localparam int unsigned LANE_W = 8;
    localparam int unsigned LANE0  = 0;
    localparam int unsigned LANE1  = 1;
    localparam int unsigned LANE2  = 2;
    localparam int unsigned LANE3  = 3;

    typedef struct packed {
        logic        ale0;
        logic        ale1;
        logic [3:0]  oe;
        logic        wr;
        logic        drive;
        logic [15:0] dout;
        logic        resp;
    } bus_ctl_t;

    // Next data phase after the address phases (or after BEAT0); beats with no enabled lanes are skipped.
    function automatic state_t next_beat(input logic [3:0] bmask, input logic past_beat0);
        if (!past_beat0 && (bmask[LANE1:LANE0] != 2'b00))
            return BEAT0;
        if (bmask[LANE3:LANE2] != 2'b00)
            return BEAT1;
        return DONE;
    endfunction

endpackage

// File: rtl/hsc_membus_ctrl_timer.sv
// Loadable phase down-counter; done is high on the last clock of a phase.
module hsc_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == W'(1));

endmodule

// File: rtl/hsc_membus_ctrl.sv
// External 16-bit multiplexed memory-bus sequencer for the hs32 core.
// Optional macro HSC_MEMBUS_ALE_CACHE_EN skips ALE_HI when addr[31:16] repeats.
module hsc_membus_ctrl #(
    parameter int PHASE_CYC = 2,
    parameter int TURN_CYC  = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_bmask,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [15:0] bus_out,
    output logic        bus_drive,
    input  logic [15:0] bus_in,
    output logic        ale0,
    output logic        ale1,
    output logic        oe0,
    output logic        oe1,
    output logic        oe2,
    output logic        oe3,
    output logic        wr
);
    import hsc_membus_pkg::*;

    localparam int MAX_CYC = (PHASE_CYC > TURN_CYC) ? PHASE_CYC : TURN_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    if (PHASE_CYC < 1) begin : g_bad_phase
        $error("hsc_membus_ctrl: PHASE_CYC must be >= 1");
    end

    state_t      state, next_state, after_addr;
    logic        accept;
    logic        phase_done, timer_load, ale_skip;
    logic [CW-1:0] timer_val;

    logic [31:0] addr_q, wdata_q, rdata_acc, rdata_nxt;
    logic [3:0]  bmask_q;
    logic        write_q;
    logic [31:0] addr_n, wdata_n;
    logic [3:0]  bmask_n;
    logic        write_n;

    bus_ctl_t    ctl_n, ctl_q;

    assign accept    = req_valid && (state == IDLE);
    assign req_ready = (state == IDLE);

    // Outputs are registered from next-state, so operands must be the values valid after this edge.
    assign addr_n  = accept ? req_addr  : addr_q;
    assign wdata_n = accept ? req_wdata : wdata_q;
    assign bmask_n = accept ? req_bmask : bmask_q;
    assign write_n = accept ? req_write : write_q;

    hsc_phase_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (phase_done)
    );

    assign timer_load = (next_state != state);
    assign timer_val  = (next_state == TURN) ? CW'(TURN_CYC) : CW'(PHASE_CYC);

`ifdef HSC_MEMBUS_ALE_CACHE_EN
    logic [15:0] hi_tag;
    logic        hi_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_tag   <= '0;
            hi_valid <= 1'b0;
        end else if (state == ALE_LO && next_state == ALE_HI) begin
            hi_tag   <= addr_q[31:16];
            hi_valid <= 1'b1;
        end
    end

    assign ale_skip = hi_valid && (hi_tag == addr_q[31:16]);
`else
    assign ale_skip = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        after_addr = (!write_q && (TURN_CYC > 0)) ? TURN : next_beat(bmask_q, 1'b0);
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ALE_LO;
            ALE_LO:  if (phase_done) next_state = ale_skip ? after_addr : ALE_HI;
            ALE_HI:  if (phase_done) next_state = after_addr;
            TURN:    if (phase_done) next_state = next_beat(bmask_q, 1'b0);
            BEAT0:   if (phase_done) next_state = next_beat(bmask_q, 1'b1);
            BEAT1:   if (phase_done) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic, evaluated for the state being entered
    always_comb begin
        ctl_n = '0;
        case (next_state)
            ALE_LO: begin
                ctl_n.drive = 1'b1;
                ctl_n.ale0  = 1'b1;
                ctl_n.dout  = addr_n[15:0];
            end
            ALE_HI: begin
                ctl_n.drive = 1'b1;
                ctl_n.ale1  = 1'b1;
                ctl_n.dout  = addr_n[31:16];
            end
            BEAT0: begin
                ctl_n.oe[LANE1:LANE0] = bmask_n[LANE1:LANE0];
                if (write_n) begin
                    ctl_n.drive = 1'b1;
                    ctl_n.wr    = 1'b1;
                    ctl_n.dout  = wdata_n[15:0];
                end
            end
            BEAT1: begin
                ctl_n.oe[LANE3:LANE2] = bmask_n[LANE3:LANE2];
                if (write_n) begin
                    ctl_n.drive = 1'b1;
                    ctl_n.wr    = 1'b1;
                    ctl_n.dout  = wdata_n[31:16];
                end
            end
            DONE:    ctl_n.resp = 1'b1;
            default: ctl_n = '0;
        endcase
    end

    // Read lanes are captured on the last clock of each beat; disabled lanes read as zero.
    always_comb begin
        rdata_nxt = rdata_acc;
        if (!write_q && phase_done) begin
            if (state == BEAT0) begin
                rdata_nxt[LANE0*LANE_W +: LANE_W] = bmask_q[LANE0] ? bus_in[7:0]  : '0;
                rdata_nxt[LANE1*LANE_W +: LANE_W] = bmask_q[LANE1] ? bus_in[15:8] : '0;
            end else if (state == BEAT1) begin
                rdata_nxt[LANE2*LANE_W +: LANE_W] = bmask_q[LANE2] ? bus_in[7:0]  : '0;
                rdata_nxt[LANE3*LANE_W +: LANE_W] = bmask_q[LANE3] ? bus_in[15:8] : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            bmask_q    <= '0;
            write_q    <= 1'b0;
            rdata_acc  <= '0;
            resp_rdata <= '0;
            ctl_q      <= '0;
        end else begin
            ctl_q <= ctl_n;
            if (accept) begin
                addr_q    <= req_addr;
                wdata_q   <= req_wdata;
                bmask_q   <= req_bmask;
                write_q   <= req_write;
                rdata_acc <= '0;
            end else begin
                rdata_acc <= rdata_nxt;
            end
            if (next_state == DONE && state != DONE)
                resp_rdata <= rdata_nxt;
        end
    end

    assign ale0       = ctl_q.ale0;
    assign ale1       = ctl_q.ale1;
    assign oe0        = ctl_q.oe[LANE0];
    assign oe1        = ctl_q.oe[LANE1];
    assign oe2        = ctl_q.oe[LANE2];
    assign oe3        = ctl_q.oe[LANE3];
    assign wr         = ctl_q.wr;
    assign bus_drive  = ctl_q.drive;
    assign bus_out    = ctl_q.dout;
    assign resp_valid = ctl_q.resp;

endmodule

// File: tb/tb_hsc_membus_ctrl.sv
// Directed self-checking bench for hsc_membus_ctrl at default parameters.
module tb_hsc_membus_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_bmask;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [15:0] bus_out, bus_in;
    logic        bus_drive, ale0, ale1, oe0, oe1, oe2, oe3, wr;

    int errors = 0;
    int checks = 0;

    // Per-cycle trace: {resp_valid, req_ready, wr, bus_drive, ale1, ale0, oe3, oe2, oe1, oe0}
    logic [9:0]  t_ctl [0:15];
    logic [15:0] t_out [0:15];
    logic [31:0] t_rd  [0:15];

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    hsc_membus_ctrl #(.PHASE_CYC(2), .TURN_CYC(1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_bmask  (req_bmask),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .bus_out    (bus_out),
        .bus_drive  (bus_drive),
        .bus_in     (bus_in),
        .ale0       (ale0),
        .ale1       (ale1),
        .oe0        (oe0),
        .oe1        (oe1),
        .oe2        (oe2),
        .oe3        (oe3),
        .wr         (wr)
    );

    function automatic logic [9:0] ctl_now();
        return {resp_valid, req_ready, wr, bus_drive, ale1, ale0, oe3, oe2, oe1, oe0};
    endfunction

    // Issues one request from a negedge with the DUT idle and records cycles 1..ncyc.
    // Acts as the memory: junk on the first clock of a read beat, real data on the second.
    task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] bm, input logic [15:0] lo_val,
                           input logic [15:0] hi_val, input int ncyc);
        logic b0, b1, prev_b0, prev_b1;
        req_write = w; req_addr = a; req_wdata = wd; req_bmask = bm; req_valid = 1'b1;
        prev_b0 = 1'b0; prev_b1 = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            t_ctl[c] = ctl_now();
            t_out[c] = bus_out;
            t_rd[c]  = resp_rdata;
            b0 = (oe0 | oe1) & ~bus_drive;
            b1 = (oe2 | oe3) & ~bus_drive;
            bus_in = b0 ? (prev_b0 ? lo_val : 16'h5A5A) :
                     b1 ? (prev_b1 ? hi_val : 16'hA5A5) : 16'hFFFF;
            prev_b0 = b0;
            prev_b1 = b1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        checks++;
        if ((ctl_now() & 10'h2FF) !== 10'h000) begin
            errors++; $display("FAIL reset_strobes: got %h want 000", ctl_now() & 10'h2FF);
        end
        checks++;
        if (bus_out !== 16'h0000) begin errors++; $display("FAIL reset_bus_out: got %h want 0000", bus_out); end
        checks++;
        if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_read_full();
        logic [9:0] exp [1:11];
        exp = '{10'h050, 10'h050, 10'h060, 10'h060, 10'h000, 10'h003, 10'h003,
                10'h00C, 10'h00C, 10'h200, 10'h100};
        run_txn(1'b0, 32'h0001_2345, 32'h0, 4'hF, 16'hBEEF, 16'hCAFE, 11);
        for (int c = 1; c <= 11; c++) begin
            checks++;
            if (t_ctl[c] !== exp[c]) begin
                errors++; $display("FAIL read_full_ctl c%0d: got %h want %h", c, t_ctl[c], exp[c]);
            end
        end
        checks++;
        if (t_out[1] !== 16'h2345 || t_out[2] !== 16'h2345) begin
            errors++; $display("FAIL read_full_alelo: got %h/%h want 2345", t_out[1], t_out[2]);
        end
        checks++;
        if (t_out[3] !== 16'h0001 || t_out[4] !== 16'h0001) begin
            errors++; $display("FAIL read_full_alehi: got %h/%h want 0001", t_out[3], t_out[4]);
        end
        checks++;
        if (t_rd[10] !== 32'hCAFE_BEEF) begin
            errors++; $display("FAIL read_full_rdata: got %h want cafebeef", t_rd[10]);
        end
    endtask

    task automatic test_read_nomask();
        logic [9:0] exp [1:7];
        exp = '{10'h050, 10'h050, 10'h060, 10'h060, 10'h000, 10'h200, 10'h100};
        run_txn(1'b0, 32'h0003_0020, 32'h0, 4'h0, 16'h1111, 16'h2222, 7);
        for (int c = 1; c <= 7; c++) begin
            checks++;
            if (t_ctl[c] !== exp[c]) begin
                errors++; $display("FAIL nomask_ctl c%0d: got %h want %h", c, t_ctl[c], exp[c]);
            end
        end
        checks++;
        if (t_out[1] !== 16'h0020 || t_out[3] !== 16'h0003) begin
            errors++; $display("FAIL nomask_addr: got %h/%h want 0020/0003", t_out[1], t_out[3]);
        end
        checks++;
        if (t_rd[6] !== 32'h0) begin errors++; $display("FAIL nomask_rdata: got %h want 0", t_rd[6]); end
    endtask

    task automatic test_write_lo();
        logic [9:0] exp [1:8];
        exp = '{10'h050, 10'h050, 10'h060, 10'h060, 10'h0C3, 10'h0C3, 10'h200, 10'h100};
        run_txn(1'b1, 32'h0002_0010, 32'h1122_3344, 4'h3, 16'h0, 16'h0, 8);
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (t_ctl[c] !== exp[c]) begin
                errors++; $display("FAIL write_lo_ctl c%0d: got %h want %h", c, t_ctl[c], exp[c]);
            end
        end
        checks++;
        if (t_out[1] !== 16'h0010 || t_out[3] !== 16'h0002) begin
            errors++; $display("FAIL write_lo_addr: got %h/%h want 0010/0002", t_out[1], t_out[3]);
        end
        checks++;
        if (t_out[5] !== 16'h3344 || t_out[6] !== 16'h3344) begin
            errors++; $display("FAIL write_lo_data: got %h/%h want 3344", t_out[5], t_out[6]);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp [1:11];
        int lat;
`ifdef HSC_MEMBUS_ALE_CACHE_EN
        exp = '{10'h050, 10'h050, 10'h000, 10'h003, 10'h003, 10'h00C, 10'h00C,
                10'h200, 10'h100, 10'h100, 10'h100};
        lat = 8;
`else
        exp = '{10'h050, 10'h050, 10'h060, 10'h060, 10'h000, 10'h003, 10'h003,
                10'h00C, 10'h00C, 10'h200, 10'h100};
        lat = 10;
`endif
        run_txn(1'b0, 32'h0004_0100, 32'h0, 4'hF, 16'h1234, 16'h5678, 11);
        checks++;
        if (t_ctl[10] !== 10'h200 || t_rd[10] !== 32'h5678_1234) begin
            errors++; $display("FAIL b2b_first: ctl %h rdata %h want 200 56781234", t_ctl[10], t_rd[10]);
        end
        run_txn(1'b0, 32'h0004_0200, 32'h0, 4'hF, 16'h9ABC, 16'hDEF0, 11);
        for (int c = 1; c <= 11; c++) begin
            checks++;
            if (t_ctl[c] !== exp[c]) begin
                errors++; $display("FAIL b2b_second_ctl c%0d: got %h want %h", c, t_ctl[c], exp[c]);
            end
        end
        checks++;
        if (t_out[1] !== 16'h0200) begin errors++; $display("FAIL b2b_second_addr: got %h want 0200", t_out[1]); end
        checks++;
        if (t_rd[lat] !== 32'hDEF0_9ABC) begin
            errors++; $display("FAIL b2b_second_rdata: got %h want def09abc", t_rd[lat]);
        end
    endtask

    task automatic test_reset_midbeat();
        logic seen_resp;
        run_txn(1'b0, 32'h0008_0000, 32'h0, 4'hF, 16'h7777, 16'h8888, 6);
        checks++;
        if (t_ctl[6] !== 10'h003) begin errors++; $display("FAIL midbeat_in_beat0: got %h want 003", t_ctl[6]); end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ((ctl_now() & 10'h2FF) !== 10'h000) begin
            errors++; $display("FAIL midbeat_async_drop: got %h want 000", ctl_now() & 10'h2FF);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        seen_resp = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) seen_resp = 1'b1;
            checks++;
            if (req_ready !== 1'b1) begin errors++; $display("FAIL midbeat_ready c%0d: got %b want 1", c, req_ready); end
        end
        checks++;
        if (seen_resp !== 1'b0) begin errors++; $display("FAIL midbeat_no_resp: got %b want 0", seen_resp); end
    endtask

    task automatic test_busy_ignore();
        logic [9:0] exp [1:11];
        int k;
        exp = '{10'h050, 10'h050, 10'h060, 10'h060, 10'h0C3, 10'h0C3,
                10'h0CC, 10'h0CC, 10'h200, 10'h100, 10'h050};
        req_write = 1'b1; req_addr = 32'h0006_1111; req_wdata = 32'hAAAA_5555;
        req_bmask = 4'hF; req_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            t_ctl[c] = ctl_now();
            t_out[c] = bus_out;
            req_addr  = (c >= 10) ? 32'h0007_ABCD : 32'h0009_0000 + 32'(c);
            req_wdata = (c >= 10) ? 32'h1357_2468 : 32'hFFFF_0000 + 32'(c);
            if (c == 11) req_valid = 1'b0;
        end
        for (int c = 1; c <= 11; c++) begin
            checks++;
            if (t_ctl[c] !== exp[c]) begin
                errors++; $display("FAIL busy_ctl c%0d: got %h want %h", c, t_ctl[c], exp[c]);
            end
        end
        checks++;
        if (t_out[1] !== 16'h1111 || t_out[3] !== 16'h0006) begin
            errors++; $display("FAIL busy_first_addr: got %h/%h want 1111/0006", t_out[1], t_out[3]);
        end
        checks++;
        if (t_out[5] !== 16'h5555 || t_out[7] !== 16'hAAAA) begin
            errors++; $display("FAIL busy_first_data: got %h/%h want 5555/aaaa", t_out[5], t_out[7]);
        end
        checks++;
        if (t_out[11] !== 16'hABCD) begin errors++; $display("FAIL busy_second_addr: got %h want abcd", t_out[11]); end
        k = 12;
        while (k < 40 && resp_valid !== 1'b1) begin
            @(negedge clk);
            if (resp_valid !== 1'b1) k++;
        end
        checks++;
        if (k !== 19) begin errors++; $display("FAIL busy_second_resp_cycle: got %0d want 19", k); end
        @(negedge clk);
    endtask

    initial begin
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_bmask = '0; bus_in = 16'hFFFF;
        test_reset();
        test_read_full();
        test_read_nomask();
        test_write_lo();
        test_back_to_back();
        test_reset_midbeat();
        test_busy_ignore();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
